wait_sequencer: RTL and testbench

Initiator for the waiter start/busy handshake. It holds a small table of delay values and plays them back in order. For each step it pulses start with the step's count value, then tracks the waiter's busy flag until the delay completes. It sits between control logic and a Waiter instance, and turns a one-shot timer into a programmable multi-step (optionally looping) delay schedule with timeout detection.

---
 rtl/wait_sequencer.sv | 163 ++++++++++++++++
 tb/tb_wait_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_sequencer.sv
// Multi-step delay sequencer: plays a table of count values into a one-shot waiter
// through its start/busy handshake, with optional looping and a busy-rise timeout.
module wait_sequencer #(
  parameter int COUNTER_SIZE = 8,
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [COUNTER_SIZE-1:0] wr_data_i,
  input  logic [ADDR_W:0]         length_i,
  input  logic                    loop_i,
  input  logic                    go_i,
  input  logic                    abort_i,
  output logic                    wait_start_o,
  output logic [COUNTER_SIZE-1:0] wait_count_to_o,
  input  logic                    wait_busy_i,
  output logic                    active_o,
  output logic [ADDR_W-1:0]       step_idx_o,
  output logic                    step_done_o,
  output logic                    seq_done_o,
  output logic                    error_o
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0]     TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_WAIT,
    S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       step_q, step_d;
  logic [ADDR_W:0]         len_q, len_d;
  logic                    loop_q, loop_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [COUNTER_SIZE-1:0] count_q, count_d;
  logic                    error_q, error_d;
  logic [COUNTER_SIZE-1:0] tbl_q [DEPTH];
  logic                    load;
  logic                    last_step;
  logic                    len_ok;

  assign last_step = ({1'b0, step_q} == (len_q - 1'b1));
  assign len_ok    = (length_i != '0) && (length_i <= DEPTH_L);

  // Delay table: writable at any time, reads are picked up only when a step issues.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (wr_en_i) begin
      tbl_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      timer_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      timer_q <= timer_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    loop_d  = loop_q;
    timer_d = timer_q;
    count_d = count_q;
    error_d = error_q;
    load    = 1'b0;
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_i && !abort_i) begin
            if (len_ok) begin
              len_d   = length_i;
              loop_d  = loop_i;
              error_d = 1'b0;
              step_d  = '0;
              state_d = S_ISSUE;
              load    = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          timer_d = '0;
          state_d = S_ACK;
        end
        S_ACK: begin
          if (wait_busy_i) begin
            state_d = S_WAIT;
          end else begin
            timer_d = timer_q + 1'b1;
            if ((timer_q + 1'b1) == TIMER_LAST) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!wait_busy_i) begin
            if (!last_step) begin
              step_d  = step_q + 1'b1;
              state_d = S_ISSUE;
              load    = 1'b1;
            end else if (loop_q) begin
              step_d  = '0;
              state_d = S_ISSUE;
              load    = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ERR: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    // count_to is captured as the step issues so it stays stable for the whole step
    if (load) count_d = tbl_q[step_d];
  end

  always_comb begin
    wait_start_o    = (state_q == S_ISSUE);
    active_o        = (state_q == S_ISSUE) || (state_q == S_ACK) || (state_q == S_WAIT);
    step_done_o     = (state_q == S_WAIT) && !wait_busy_i && !abort_i;
    seq_done_o      = step_done_o && last_step && !loop_q;
    wait_count_to_o = count_q;
    step_idx_o      = step_q;
    error_o         = error_q;
  end

endmodule

// File: tb/tb_wait_sequencer.sv
// Self-checking bench for wait_sequencer: a behavioural waiter plus event queues,
// compared against timelines computed arithmetically from the table contents.
module tb_wait_sequencer;
  localparam int CS = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int AT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CS-1:0] wr_data = '0;
  logic [AW:0]   length = '0;
  logic          loop = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          wait_start;
  logic [CS-1:0] wait_count_to;
  logic          wait_busy;
  logic          active;
  logic [AW-1:0] step_idx;
  logic          step_done;
  logic          seq_done;
  logic          error;

  wait_sequencer #(.COUNTER_SIZE(CS), .DEPTH(DEPTH), .ADDR_W(AW), .ACK_TIMEOUT(AT)) dut (
    .clock_i(clk), .reset_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .length_i(length), .loop_i(loop), .go_i(go), .abort_i(abort),
    .wait_start_o(wait_start), .wait_count_to_o(wait_count_to), .wait_busy_i(wait_busy),
    .active_o(active), .step_idx_o(step_idx), .step_done_o(step_done),
    .seq_done_o(seq_done), .error_o(error)
  );

  always #5 clk = ~clk;

  // Waiter model: busy rises rise_d cycles after the start cycle and lasts count_to cycles.
  int cyc = 0;
  int s_cyc = -1000;
  int n_busy = 0;
  int rise_d = 1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wait_start) begin
      s_cyc  <= cyc;
      n_busy <= int'(wait_count_to);
    end
  end
  assign wait_busy = (cyc >= s_cyc + rise_d) && (cyc < s_cyc + rise_d + n_busy);

  int st_cyc[$], st_cnt[$], st_idx[$], sd_cyc[$], sq_cyc[$], af_cyc[$], er_cyc[$];
  logic prev_act = 1'b0;
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    if (wait_start) begin
      st_cyc.push_back(cyc);
      st_cnt.push_back(int'(wait_count_to));
      st_idx.push_back(int'(step_idx));
    end
    if (step_done) sd_cyc.push_back(cyc);
    if (seq_done) sq_cyc.push_back(cyc);
    if (prev_act && !active) af_cyc.push_back(cyc);
    if (!prev_err && error) er_cyc.push_back(cyc);
    prev_act <= active;
    prev_err <= error;
  end

  int checks = 0;
  int errors = 0;
  int tbl_m[DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    st_cyc.delete(); st_cnt.delete(); st_idx.delete();
    sd_cyc.delete(); sq_cyc.delete(); af_cyc.delete(); er_cyc.delete();
  endtask

  task automatic write_entry(input int a, input int v);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = CS'(v);
    step();
    wr_en = 1'b0;
    tbl_m[a] = v;
    $display("write   entry %0d = %0d", a, v);
  endtask

  task automatic start_run(input int len, input bit lp, output int g);
    length = (AW + 1)'(len);
    loop = lp;
    go = 1'b1;
    g = cyc;
    step();
    go = 1'b0;
    $display("go      length=%0d loop=%0d at cycle %0d", len, lp, g);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (active && n < budget) begin
      step();
      n++;
    end
    check("run_end_active", active, 0);
    @(negedge clk);
    #1;
  endtask

  // Expected timeline: step i issues at t, busy ends after rise_d+c cycles, next issue right after.
  task automatic check_run(input string tag, input int g, input int len);
    int t = g + 1;
    int done = 0;
    check({tag, ".nstart"}, st_cyc.size(), len);
    for (int i = 0; i < len; i++) begin
      if (i < st_cyc.size()) begin
        check({tag, ".start_cyc"}, st_cyc[i], t);
        check({tag, ".count_to"}, st_cnt[i], tbl_m[i]);
        check({tag, ".step_idx"}, st_idx[i], i);
      end
      done = t + rise_d + tbl_m[i];
      if (i < sd_cyc.size()) check({tag, ".step_done_cyc"}, sd_cyc[i], done);
      t = done + 1;
    end
    check({tag, ".nstep_done"}, sd_cyc.size(), len);
    check({tag, ".nseq_done"}, sq_cyc.size(), 1);
    if (sq_cyc.size() > 0) check({tag, ".seq_done_cyc"}, sq_cyc[0], done);
    check({tag, ".nfall"}, af_cyc.size(), 1);
    if (af_cyc.size() > 0) check({tag, ".active_fall"}, af_cyc[0], done + 1);
    $display("run     %s length=%0d rise_d=%0d checked", tag, len, rise_d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".wait_start"}, wait_start, 0);
    check({tag, ".count_to"}, wait_count_to, 0);
    check({tag, ".active"}, active, 0);
    check({tag, ".step_idx"}, step_idx, 0);
    check({tag, ".step_done"}, step_done, 0);
    check({tag, ".seq_done"}, seq_done, 0);
    check({tag, ".error"}, error, 0);
  endtask

  initial begin
    int g;
    int n;
    int t0;
    int len;
    for (int i = 0; i < DEPTH; i++) tbl_m[i] = 0;

    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // Reset during WAIT of step 0
    write_entry(0, 10);
    write_entry(1, 3);
    clear_q();
    rise_d = 1;
    start_run(2, 1'b0, g);
    n = 0;
    while (!wait_busy && n < 20) begin step(); n++; end
    step();
    step();
    check("midrst.active_pre", active, 1);
    #2 rst = 1'b1;
    #1;
    check_zero("midrst");
    step();
    rst = 1'b0;
    $display("reset   asserted mid-run and released");
    for (int i = 0; i < DEPTH; i++) tbl_m[i] = 0;
    repeat (12) step();
    check("midrst.idle", active, 0);

    // Table reads back 0; a zero count never raises busy so the timeout fires
    clear_q();
    start_run(1, 1'b0, g);
    wait_idle(40);
    t0 = g + 1;
    check("tmo.nstart", st_cyc.size(), 1);
    if (st_cyc.size() > 0) check("tmo.count_to", st_cnt[0], 0);
    check("tmo.nerr", er_cyc.size(), 1);
    if (er_cyc.size() > 0) check("tmo.err_cyc", er_cyc[0], t0 + AT);
    check("tmo.nfall", af_cyc.size(), 1);
    if (af_cyc.size() > 0) check("tmo.fall_cyc", af_cyc[0], t0 + AT);
    check("tmo.nstep_done", sd_cyc.size(), 0);
    check("tmo.nseq_done", sq_cyc.size(), 0);
    repeat (3) step();
    check("tmo.sticky", error, 1);

    // Basic run; the valid go clears the sticky error
    write_entry(0, 10);
    write_entry(1, 3);
    rise_d = int'($urandom_range(1, 3));
    clear_q();
    start_run(2, 1'b0, g);
    check("basic.err_cleared", error, 0);
    wait_idle(100);
    check_run("basic", g, 2);

    // Live write: entry 1 rewritten during step 0, then again during step 1
    clear_q();
    start_run(2, 1'b0, g);
    step();
    write_entry(1, 7);
    n = 0;
    while (st_cyc.size() < 2 && n < 60) begin step(); n++; end
    check("live.nstart", st_cyc.size(), 2);
    if (st_cyc.size() > 1) check("live.issue_count", st_cnt[1], 7);
    check("live.count_to_now", wait_count_to, 7);
    write_entry(1, 20);
    check("live.count_to_held", wait_count_to, 7);
    wait_idle(100);
    clear_q();
    start_run(2, 1'b0, g);
    wait_idle(100);
    check_run("live2", g, 2);

    // Randomized non-looping runs
    for (int k = 0; k < 3; k++) begin
      len = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < len; i++) write_entry(i, int'($urandom_range(1, 12)));
      rise_d = int'($urandom_range(1, 3));
      clear_q();
      start_run(len, 1'b0, g);
      wait_idle(400);
      check_run("rand", g, len);
    end

    // go and abort together in IDLE: nothing starts
    clear_q();
    abort = 1'b1;
    start_run(1, 1'b0, g);
    abort = 1'b0;
    step();
    check("goabort.active", active, 0);
    check("goabort.nstart", st_cyc.size(), 0);

    // Looping run, then abort during WAIT of the fifth step
    write_entry(0, 2);
    write_entry(1, 4);
    write_entry(2, 6);
    rise_d = int'($urandom_range(1, 3));
    clear_q();
    start_run(3, 1'b1, g);
    n = 0;
    while (st_cyc.size() < 5 && n < 200) begin step(); n++; end
    check("loop.nstart", st_cyc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < st_cyc.size()) begin
        check("loop.step_idx", st_idx[i], i % 3);
        check("loop.count_to", st_cnt[i], tbl_m[i % 3]);
      end
    end
    if (st_cyc.size() > 1) check("loop.gap", st_cyc[1] - st_cyc[0], rise_d + 2 + 1);
    if (st_cyc.size() > 3) check("loop.wrap_gap", st_cyc[3] - st_cyc[2], rise_d + 6 + 1);
    check("loop.nseq_done", sq_cyc.size(), 0);
    n = 0;
    while (!wait_busy && n < 20) begin step(); n++; end
    step();
    check("abort.active_pre", active, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    $display("abort   issued during WAIT");
    check("abort.active", active, 0);
    check("abort.step_idx", step_idx, 1);
    check("abort.wait_start", wait_start, 0);
    repeat (6) step();
    check("abort.nstep_done", sd_cyc.size(), 4);
    check("abort.nseq_done", sq_cyc.size(), 0);
    check("abort.nstart", st_cyc.size(), 5);

    // Bad lengths
    clear_q();
    start_run(0, 1'b0, g);
    step();
    check("len0.error", error, 1);
    check("len0.active", active, 0);
    start_run(1, 1'b0, g);
    check("len0.err_cleared", error, 0);
    wait_idle(100);
    start_run(9, 1'b0, g);
    step();
    check("len9.error", error, 1);
    check("len9.active", active, 0);
    check("bad.nstart", st_cyc.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
